// File: rtl/bus_xcvr_arbiter_pkg.sv
// Shared types and constants for the bus transceiver arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  localparam int HOLD_W = 8;
  localparam int TURN_W = 3;

  // Index width for a requester vector; never narrower than one bit.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bus_xcvr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface bus_xcvr_arbiter_if #(
  parameter int N_REQ = 4
);
  import bus_arb_pkg::*;

  localparam int IDX_W = clog2_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] oe_n;
  logic [IDX_W-1:0] owner;
  logic             bus_idle;
  logic             preempt;

  modport master (output req, input grant, oe_n, owner, bus_idle, preempt);
  modport slave  (input req, output grant, oe_n, owner, bus_idle, preempt);

endinterface

// File: rtl/bus_xcvr_arbiter_rr_pick.sv
// Round-robin selector: rotate requests by the pointer, pick the lowest set bit,
// then map the position back to an absolute requester index.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot_s;
  int               first_s;
  int               sum_s;

  // Rotate, priority-encode, un-rotate.
  always_comb begin
    rot_s   = {N_REQ{1'b0}};
    first_s = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rot_s[i] = req[IDX_W'((i + int'(ptr)) % N_REQ)];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        first_s = i;
      end else begin
        first_s = first_s;
      end
    end
    sum_s = first_s + int'(ptr);
    if (sum_s >= N_REQ) begin
      sum_s = sum_s - N_REQ;
    end else begin
      sum_s = sum_s;
    end
    found = |rot_s;
    idx   = IDX_W'(sum_s);
  end

endmodule

// File: rtl/bus_xcvr_arbiter.sv
// Round-robin owner of the shared data bus; drives one transceiver enable at a
// time with dead cycles between owners and optional ownership time limit.
module bus_xcvr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_xcvr_arbiter_if.slave  bus
);

  localparam int                IDX_W     = clog2_w(N_REQ);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
  localparam logic [TURN_W-1:0] TURN_INIT = TURN_W'(TURNAROUND);
  localparam logic [TURN_W-1:0] TURN_LAST = {{(TURN_W-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0]  ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e        state_r;
  logic [N_REQ-1:0]  grant_r;
  logic [N_REQ-1:0]  oe_n_r;
  logic [IDX_W-1:0]  owner_r;
  logic              bus_idle_r;
  logic              preempt_r;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [HOLD_W-1:0] hold_r;
  logic [TURN_W-1:0] tcnt_r;

  logic              pick_found_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic [N_REQ-1:0]  pick_onehot_s;
  logic              owner_req_s;
  logic              hold_done_s;
  logic [IDX_W-1:0]  next_ptr_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Decode helpers for the state register.
  always_comb begin
    pick_onehot_s = ONE_HOT0 << pick_idx_s;
    owner_req_s   = bus.req[owner_r];
    hold_done_s   = (MAX_HOLD != 0) && (hold_r == HOLD_LIM);
    if (owner_r == LAST_IDX) begin
      next_ptr_s = {IDX_W{1'b0}};
    end else begin
      next_ptr_s = owner_r + IDX_W'(1);
    end
  end

  // Arbitration FSM; every output is a register so enables never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant_r    <= {N_REQ{1'b0}};
      oe_n_r     <= {N_REQ{1'b1}};
      owner_r    <= {IDX_W{1'b0}};
      bus_idle_r <= 1'b1;
      preempt_r  <= 1'b0;
      rr_ptr_r   <= {IDX_W{1'b0}};
      hold_r     <= {HOLD_W{1'b0}};
      tcnt_r     <= {TURN_W{1'b0}};
    end else begin
      preempt_r <= 1'b0;
      case (state_r)
        IDLE, TURN: begin
          // TURN counts down; its final edge doubles as the arbitration edge.
          if ((state_r == TURN) && (tcnt_r != TURN_LAST)) begin
            tcnt_r <= tcnt_r - TURN_LAST;
          end else if (pick_found_s) begin
            grant_r    <= pick_onehot_s;
            oe_n_r     <= ~pick_onehot_s;
            owner_r    <= pick_idx_s;
            bus_idle_r <= 1'b0;
            hold_r     <= {{(HOLD_W-1){1'b0}}, 1'b1};
            state_r    <= OWN;
          end else begin
            state_r <= IDLE;
          end
        end
        OWN: begin
          if (!owner_req_s || hold_done_s) begin
            grant_r    <= {N_REQ{1'b0}};
            oe_n_r     <= {N_REQ{1'b1}};
            owner_r    <= {IDX_W{1'b0}};
            bus_idle_r <= 1'b1;
            rr_ptr_r   <= next_ptr_s;
            tcnt_r     <= TURN_INIT;
            preempt_r  <= owner_req_s;
            state_r    <= TURN;
          end else if (hold_r != HOLD_SAT) begin
            hold_r <= hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
          end else begin
            hold_r <= hold_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          grant_r    <= {N_REQ{1'b0}};
          oe_n_r     <= {N_REQ{1'b1}};
          owner_r    <= {IDX_W{1'b0}};
          bus_idle_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.grant    = grant_r;
  assign bus.oe_n     = oe_n_r;
  assign bus.owner    = owner_r;
  assign bus.bus_idle = bus_idle_r;
  assign bus.preempt  = preempt_r;

endmodule

// File: tb/tb_bus_xcvr_arbiter.sv
// Directed bench: a table of req/expected-output vectors for the default
// configuration plus short sequences for reset, short hold and unlimited hold.
module tb_bus_xcvr_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       preempt;
  } vec_t;

  logic clk;
  logic rst_a_n;
  logic rst_bc_n;
  int   n_vec;
  int   n_bad;
  vec_t tbl[$];

  bus_xcvr_arbiter_if #(.N_REQ(4)) bus_a ();
  bus_xcvr_arbiter_if #(.N_REQ(4)) bus_b ();
  bus_xcvr_arbiter_if #(.N_REQ(4)) bus_c ();

  bus_xcvr_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(8)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(bus_a)
  );
  bus_xcvr_arbiter #(.N_REQ(4), .TURNAROUND(3), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_bc_n), .bus(bus_b)
  );
  bus_xcvr_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(0)) dut_c (
    .clk(clk), .rst_n(rst_bc_n), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                              input logic [1:0] o, input logic p);
    vec_t v;
    v.req = r; v.grant = g; v.owner = o; v.preempt = p;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int k,
                     input logic [3:0] ag, input logic [3:0] aoe,
                     input logic [1:0] ao, input logic ap, input logic ai,
                     input vec_t e);
    logic [3:0] eoe;
    logic       ei;
    eoe = ~e.grant;
    ei  = (e.grant == 4'b0000);
    n_vec++;
    if ({ag, aoe, ao, ap, ai} !== {e.grant, eoe, e.owner, e.preempt, ei}) begin
      n_bad++;
      $display("FAIL %s[%0d]: got grant=%b oe_n=%b owner=%0d preempt=%b idle=%b, want grant=%b oe_n=%b owner=%0d preempt=%b idle=%b",
               nm, k, ag, aoe, ao, ap, ai, e.grant, eoe, e.owner, e.preempt, ei);
    end
  endtask

  initial begin
    logic [3:0] oh;
    int         own_seq[5];
    vec_t       e;

    n_vec = 0;
    n_bad = 0;
    rst_a_n  = 1'b0;
    rst_bc_n = 1'b0;
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;
    bus_c.req = 4'b0000;

    // Reset idle, single request, voluntary release with nothing waiting.
    for (int i = 0; i < 10; i++) tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
    for (int i = 0; i < 2; i++)  tbl.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b0));
    for (int i = 0; i < 2; i++)  tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
    // Early release of requester 0 with requester 1 pending.
    for (int i = 0; i < 3; i++)  tbl.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b0));
    tbl.push_back(mk(4'b0010, 4'b0000, 2'd0, 1'b0));
    tbl.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b0));
    for (int i = 0; i < 2; i++)  tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
    // Everyone requesting: pointer sits at 2, 8-cycle slots, one dead cycle.
    own_seq = '{2, 3, 0, 1, 2};
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << own_seq[k];
      for (int i = 0; i < 8; i++) tbl.push_back(mk(4'b1111, oh, 2'(own_seq[k]), 1'b0));
      tbl.push_back(mk(4'b1111, 4'b0000, 2'd0, 1'b1));
    end
    tbl.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b0));

    #12;
    rst_a_n  = 1'b1;
    rst_bc_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      bus_a.req = tbl[i].req;
      step();
      chk("tbl", i, bus_a.grant, bus_a.oe_n, bus_a.owner, bus_a.preempt, bus_a.bus_idle, tbl[i]);
    end

    // Asynchronous reset while requester 3 owns the bus.
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("async_rst", 0, bus_a.grant, bus_a.oe_n, bus_a.owner, bus_a.preempt, bus_a.bus_idle,
        mk(4'b1000, 4'b0000, 2'd0, 1'b0));
    #2;
    rst_a_n   = 1'b1;
    bus_a.req = 4'b1001;
    step();
    chk("post_rst", 0, bus_a.grant, bus_a.oe_n, bus_a.owner, bus_a.preempt, bus_a.bus_idle,
        mk(4'b1001, 4'b0001, 2'd0, 1'b0));

    // Sole requester, MAX_HOLD=4, TURNAROUND=3: 4 granted, 3 idle, repeated.
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0010;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 7; c++) begin
        step();
        if (c < 4) e = mk(4'b0010, 4'b0010, 2'd1, 1'b0);
        else       e = mk(4'b0010, 4'b0000, 2'd0, (c == 4) ? 1'b1 : 1'b0);
        chk("sole", r * 7 + c, bus_b.grant, bus_b.oe_n, bus_b.owner, bus_b.preempt, bus_b.bus_idle, e);
      end
    end
    bus_b.req = 4'b0000;

    // Unlimited hold: requester 0 keeps the bus past hold-counter saturation.
    bus_c.req = 4'b0011;
    for (int i = 0; i < 300; i++) begin
      step();
      chk("nolimit", i, bus_c.grant, bus_c.oe_n, bus_c.owner, bus_c.preempt, bus_c.bus_idle,
          mk(4'b0011, 4'b0001, 2'd0, 1'b0));
    end
    bus_c.req = 4'b0010;
    step();
    chk("nolimit_rel", 0, bus_c.grant, bus_c.oe_n, bus_c.owner, bus_c.preempt, bus_c.bus_idle,
        mk(4'b0010, 4'b0000, 2'd0, 1'b0));
    step();
    chk("nolimit_next", 0, bus_c.grant, bus_c.oe_n, bus_c.owner, bus_c.preempt, bus_c.bus_idle,
        mk(4'b0010, 4'b0010, 2'd1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
